// File: rtl/pixel_out_pkg.sv
// Shared constants and types for the pixel byte-to-word packer.
package pixel_out_pkg;

    localparam int unsigned PKG_OUT_MAX    = 262144;
    localparam int unsigned PKG_FIFO_DEPTH = 8;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous word FIFO, 33-bit entries {last, data[31:0]}, show-ahead read port.
module sync_fifo
    import pixel_out_pkg::*;
#(
    parameter int unsigned DEPTH = PKG_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [32:0] wr_data_i,
    input  logic        rd_en_i,
    output logic [32:0] rd_data_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [32:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        wr_ok;
    logic        rd_ok;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // A write into a full FIFO is allowed when a read frees the head entry on the same edge.
    always_comb begin
        rd_ok    = rd_en_i && !empty_o;
        wr_ok    = wr_en_i && (!full_o || rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs a strobed byte stream into little-endian 32-bit AXI4-Stream words for one frame.
module pixel_stream_packer
    import pixel_out_pkg::*;
#(
    parameter int unsigned OUT_MAX    = PKG_OUT_MAX,
    parameter int unsigned FIFO_DEPTH = PKG_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [3:0]  m_axis_tkeep,
    output logic        done,
    output logic        overflow
);
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  lane_q, lane_d;
    logic [23:0] pack_q, pack_d;
    logic        wr_pend_q, wr_pend_d;
    logic [32:0] wr_word_q, wr_word_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        overflow_q, overflow_d;

    logic        accept;
    logic        hs;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic [32:0] fifo_rdata;

    // Byte packing: the 4th byte bypasses the pack register straight into the pending word.
    always_comb begin
        accept    = in_valid && (state_q == ACCEPT);
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        wr_pend_d = 1'b0;
        wr_word_d = wr_word_q;
        if (accept) begin
            cnt_d  = cnt_q + 32'd1;
            lane_d = lane_q + 2'd1;
            unique case (lane_q)
                2'd0: pack_d[7:0]   = in_data;
                2'd1: pack_d[15:8]  = in_data;
                2'd2: pack_d[23:16] = in_data;
                2'd3: begin
                    wr_pend_d = 1'b1;
                    wr_word_d = {(cnt_d == 32'(OUT_MAX)), in_data, pack_q};
                end
                default: ;
            endcase
        end
    end

    // Show-ahead output register: reload from the FIFO whenever empty or being consumed.
    always_comb begin
        hs         = tvalid_q && m_axis_tready;
        fifo_rd    = !fifo_empty && (state_q != DONE) && (!tvalid_q || m_axis_tready);
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        overflow_d = overflow_q | (wr_pend_q && fifo_full && !fifo_rd);
        if (state_q == DONE) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else if (fifo_rd) begin
            tvalid_d = 1'b1;
            tdata_d  = fifo_rdata[31:0];
            tlast_d  = fifo_rdata[32];
        end else if (hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    // Frame FSM next state; DRAIN also exits when nothing is left in flight (dropped last word).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCEPT: if (cnt_d == 32'(OUT_MAX)) state_d = DRAIN;
            DRAIN: begin
                if ((hs && tlast_q) || (fifo_empty && !tvalid_q && !wr_pend_q))
                    state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = ACCEPT;
        endcase
    end

    // State, packer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCEPT;
            cnt_q      <= '0;
            lane_q     <= '0;
            pack_q     <= '0;
            wr_pend_q  <= 1'b0;
            wr_word_q  <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            wr_pend_q  <= wr_pend_d;
            wr_word_q  <= wr_word_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_pend_q),
        .wr_data_i (wr_word_q),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tkeep  = 4'hF;
    assign done          = (state_q == DONE);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed self-checking bench: a 16-byte-frame instance and a default-size instance.
module tb_pixel_stream_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        tready;
    logic        sel;

    logic        va, vb;
    logic [31:0] a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_done, b_done, a_ovf, b_ovf;
    logic [3:0]  a_tkeep, b_tkeep;

    logic [31:0] tdata;
    logic        tvalid, tlast, done, ovf;

    logic [32:0] got_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign va     = in_valid & ~sel;
    assign vb     = in_valid & sel;
    assign tdata  = sel ? b_tdata  : a_tdata;
    assign tvalid = sel ? b_tvalid : a_tvalid;
    assign tlast  = sel ? b_tlast  : a_tlast;
    assign done   = sel ? b_done   : a_done;
    assign ovf    = sel ? b_ovf    : a_ovf;

    pixel_stream_packer #(
        .OUT_MAX    (16),
        .FIFO_DEPTH (8)
    ) u_small (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (va),
        .in_data       (in_data),
        .m_axis_tdata  (a_tdata),
        .m_axis_tvalid (a_tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (a_tlast),
        .m_axis_tkeep  (a_tkeep),
        .done          (a_done),
        .overflow      (a_ovf)
    );

    pixel_stream_packer u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (vb),
        .in_data       (in_data),
        .m_axis_tdata  (b_tdata),
        .m_axis_tvalid (b_tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (b_tlast),
        .m_axis_tkeep  (b_tkeep),
        .done          (b_done),
        .overflow      (b_ovf)
    );

    // Record every handshake of the selected instance, mid-cycle.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) got_q.push_back({tlast, tdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mkword(input logic [7:0] b);
        logic [7:0] b1, b2, b3;
        b1 = b + 8'd1;
        b2 = b + 8'd2;
        b3 = b + 8'd3;
        return {b3, b2, b1, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        got_q.delete();
    endtask

    // Compare the captured stream with n consecutive words starting at byte value base.
    task automatic expect_stream(input string tag, input int n, input logic [7:0] base,
                                 input int last_idx);
        logic [32:0] exp;
        check({tag, "_count"}, 64'(got_q.size()), 64'(n));
        for (int w = 0; w < n && w < got_q.size(); w++) begin
            exp = {(w == last_idx), mkword(8'(int'(base) + 4 * w))};
            check($sformatf("%s_w%0d", tag, w), 64'(got_q[w]), 64'(exp));
        end
    endtask

    initial begin
        bit hs_seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tready   = 1'b0;
        sel      = 1'b1;
        tick();
        tick();
        tick();

        // Reset values on both instances.
        check("rst_tvalid", 64'({a_tvalid, b_tvalid}), 64'd0);
        check("rst_tlast",  64'({a_tlast, b_tlast}), 64'd0);
        check("rst_tdata",  64'({a_tdata, b_tdata}), 64'd0);
        check("rst_done",   64'({a_done, b_done}), 64'd0);
        check("rst_ovf",    64'({a_ovf, b_ovf}), 64'd0);
        check("tkeep",      64'({a_tkeep, b_tkeep}), 64'hFF);
        rst = 1'b0;
        got_q.delete();

        // Single word latency: tvalid two edges after the 4th byte's accept edge.
        tready = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("lat_n0_tvalid", 64'(tvalid), 64'd0);
        tick();
        check("lat_n1_tvalid", 64'(tvalid), 64'd0);
        tick();
        check("lat_n2_tvalid", 64'(tvalid), 64'd1);
        check("lat_tdata", 64'(tdata), 64'h04030201);
        check("lat_tlast", 64'(tlast), 64'd0);
        tick();
        tick();
        check("lat_once", 64'(got_q.size()), 64'd1);

        // Mid-frame reset discards the partial word.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i));
        rst = 1'b1;
        tick();
        check("mrst_outs", 64'({tvalid, tlast, tdata, done, ovf}), 64'd0);
        tick();
        rst = 1'b0;
        got_q.delete();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        for (int i = 0; i < 4; i++) tick();
        check("mrst_cnt", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("mrst_word", 64'(got_q[0]), 64'h0_DDCCBBAA);

        // Long stall at full rate: 1 held + 8 queued, 10th word dropped.
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 36; i++) send_byte(8'(i));
        tick();
        tick();
        tick();
        check("stall_ovf9", 64'(ovf), 64'd0);
        check("stall_tvalid", 64'(tvalid), 64'd1);
        for (int i = 36; i < 40; i++) send_byte(8'(i));
        tick();
        check("stall_ovf10", 64'(ovf), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("stall_hold", 64'({tvalid, tdata}), 64'h1_03020100);
            tick();
        end
        tready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        expect_stream("stall", 9, 8'h00, -1);

        // Full FIFO with a handshake on the same edge as a word write.
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 40; i++) send_byte(8'(i));
        tready = 1'b1;
        tick();
        tready = 1'b0;
        check("full_rw_ovf", 64'(ovf), 64'd0);
        check("full_rw_next", 64'(tdata), 64'(mkword(8'd4)));
        tick();
        tready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("full_rw_ovf_end", 64'(ovf), 64'd0);
        expect_stream("full_rw", 10, 8'h00, -1);

        // tready toggling every cycle.
        do_reset();
        tready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tready = ~tready;
            send_byte(8'(8'h40 + i));
        end
        for (int i = 0; i < 20; i++) begin
            tready = ~tready;
            tick();
        end
        tready = 1'b1;
        tick();
        tick();
        check("toggle_ovf", 64'(ovf), 64'd0);
        expect_stream("toggle", 8, 8'h40, -1);

        // Complete 16-byte frame at 1 byte per 6 cycles, then done is sticky.
        sel = 1'b0;
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(8'h20 + i));
            if (i < 15) for (int k = 0; k < 5; k++) tick();
        end
        hs_seen = 1'b0;
        for (int k = 0; k < 20 && !hs_seen; k++) begin
            if (tvalid && tready && tlast) begin
                hs_seen = 1'b1;
                check("frame_done_pre", 64'(done), 64'd0);
                tick();
                check("frame_done_post", 64'(done), 64'd1);
                check("frame_tvalid_post", 64'(tvalid), 64'd0);
            end else begin
                tick();
            end
        end
        check("frame_last_seen", 64'(hs_seen), 64'd1);
        expect_stream("frame", 4, 8'h20, 3);
        send_byte(8'h99);
        for (int k = 0; k < 6; k++) tick();
        check("frame_after", 64'({done, tvalid, ovf}), 64'h4);
        check("frame_after_cnt", 64'(got_q.size()), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_stream_packer.md
PIXEL_STREAM_PACKER -- requirements
Module: pixel_stream_packer

Interface
REQ-001 Parameter OUT_MAX, default 262144, is the total bytes per frame; it SHALL be a multiple of 4.
REQ-002 Parameter FIFO_DEPTH, default 8, is the word FIFO depth in 32-bit words; it SHALL be a power of 2.
REQ-003 clk  in  1  single clock; all logic is on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  one-cycle strobe meaning in_data is valid; there is no ready back to the producer.
REQ-006 in_data  in  8  pixel byte.
REQ-007 m_axis_tdata  out  32  packed word.
REQ-008 m_axis_tvalid  out  1  AXI4-Stream valid.
REQ-009 m_axis_tready  in  1  AXI4-Stream ready.
REQ-010 m_axis_tlast  out  1  high on the final word of the frame.
REQ-011 m_axis_tkeep  out  4  constant 4'hF.
REQ-012 done  out  1  sticky; frame fully transmitted.
REQ-013 overflow  out  1  sticky; a word was dropped because the FIFO was full.

Function
REQ-014 The block SHALL pack bytes little-endian: byte k of a word goes to tdata[8k+7:8k], with the first-accepted byte in [7:0].
REQ-015 A byte SHALL be accepted only when in_valid=1 and state=ACCEPT; the 32-bit byte counter SHALL increment on each accepted byte.
REQ-016 When the 4th byte of a word is accepted on edge N, the packed word SHALL be written into the FIFO on edge N+1, together with last = (byte counter reached OUT_MAX).
REQ-017 If the FIFO is full on the write edge, the word SHALL be dropped, overflow SHALL set, and the byte counter SHALL NOT be rewound.
REQ-018 If a frame's last word is dropped, done SHALL still set once the FIFO drains.
REQ-019 The output is a registered show-ahead stage; with an empty FIFO and tready=1, tvalid SHALL rise on edge N+2 after the 4th byte's accept edge N.
REQ-020 Once tvalid=1, tvalid, tdata and tlast SHALL hold until a cycle with tready=1.
REQ-021 A handshake occurs on any cycle with tvalid=1 and tready=1.
REQ-022 After a handshake, the next FIFO word SHALL be presented on the following cycle, with no bubble when the FIFO is non-empty.
REQ-023 tlast SHALL equal the stored last bit of the presented word.
REQ-024 Simultaneous FIFO write and read SHALL be legal when full: the read frees the entry, the write succeeds, and overflow does not set.
REQ-025 FSM state ACCEPT SHALL be the reset state; it moves to DRAIN when the byte counter reaches OUT_MAX.
REQ-026 FSM state DRAIN SHALL ignore in_valid; it moves to DONE after the handshake of the tlast word, or when the FIFO and output stage are empty.
REQ-027 FSM state DONE SHALL ignore in_valid, hold done=1 and tvalid=0, and exit only on rst.
REQ-028 in_valid on consecutive cycles SHALL be accepted at full rate (1 byte per cycle), even though the nominal upstream rate is 1 byte per 6 cycles.

Reset
REQ-029 While rst=1 the block SHALL hold state=ACCEPT, byte counter=0, pack register and lane index=0, and FIFO pointers=0.
REQ-030 While rst=1 the outputs SHALL be tvalid=0, tlast=0, tdata=0, done=0, overflow=0.
REQ-031 Asserting rst mid-frame SHALL discard the partial word and all FIFO contents; the next frame restarts at byte 0.

Structure
REQ-032 A shared package/header pixel_out_pkg SHALL hold OUT_MAX, FIFO_DEPTH, and the state encoding ACCEPT=2'd0, DRAIN=2'd1, DONE=2'd2.
REQ-033 The FIFO SHALL be a sub-module sync_fifo: 33-bit entries (32 data + 1 last), with full/empty flags and read/write enables.
REQ-034 The packer, FSM and output register stage SHALL live in the top module.

Verification
REQ-035 Bytes 0x01,0x02,0x03,0x04, tready=1 -> one word 0x04030201 with tvalid exactly 2 cycles after the 4th strobe, tlast=0.
REQ-036 OUT_MAX=16, 16 bytes at 1 byte per 6 cycles, tready=1 -> 4 words; tlast=1 only on word 4; done=1 the cycle after word 4's handshake; a further in_valid changes nothing.
REQ-037 tready=0 for 50 cycles mid-frame at full byte rate, FIFO_DEPTH=8 -> no more than 8 words plus the output word held; overflow=1 on the 10th completed word; tdata stays stable while stalled.
REQ-038 tready toggling 1/0 every cycle -> every word delivered exactly once, in order, with no duplicates.
REQ-039 rst pulsed after 6 bytes of a frame -> outputs return to reset values; the next 4 bytes 0xAA,0xBB,0xCC,0xDD produce 0xDDCCBBAA.
REQ-040 FIFO full with a simultaneous handshake and word write -> overflow stays 0 and the word count is preserved.
